fp_sqrt_seq: RTL and testbench

//  Inverse of the squaring block: sequential IEEE-754 single-precision square root.
//  - Operand and rounding mode arrive as two XOR shares, garbler g_input and evaluator e_input.
//  - Radix-2 restoring digit recurrence, one root bit per cycle.
//  - Latency is fixed and data-independent, as garbled-circuit sequential mode requires.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_sqrt_seq_if.sv | 20 ++
 rtl/fp_sqrt_round.sv | 48 ++++
 rtl/fp_sqrt_seq.sv | 195 +++++++++++++++++++
 tb/tb_fp_sqrt_seq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// fp_pkg : shared encodings for the sequential floating-point square root
// Revision : 1.0
// ============================================================================
package fp_pkg;

  localparam logic [2:0] RND_NE   = 3'd0;
  localparam logic [2:0] RND_ZERO = 3'd1;
  localparam logic [2:0] RND_PINF = 3'd2;
  localparam logic [2:0] RND_NINF = 3'd3;
  localparam logic [2:0] RND_UP   = 3'd4;

  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_INVALID = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ITER   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

endpackage
`default_nettype wire

// File: rtl/fp_sqrt_seq_if.sv
`default_nettype none
// ============================================================================
// fp_sqrt_seq_if : request/result bundle of the sequential square root
// Revision : 1.0
// ============================================================================
interface fp_sqrt_seq_if #(
  parameter int W = 32
);
  logic           start;
  logic [W+2:0]   g_input;
  logic [W+2:0]   e_input;
  logic           busy;
  logic           done;
  logic [W-1:0]   o;
  logic [7:0]     status;

  modport master (output start, g_input, e_input, input busy, done, o, status);
  modport slave  (input start, g_input, e_input, output busy, done, o, status);
endinterface
`default_nettype wire

// File: rtl/fp_sqrt_round.sv
`default_nettype none
// ============================================================================
// fp_sqrt_round : rounds the raw root (int, fraction, guard, round) + sticky
// Revision : 1.0
// ============================================================================
module fp_sqrt_round
  import fp_pkg::*;
#(
  parameter int SIG = 23
) (
  input  logic [SIG+2:0] root_i,
  input  logic           sticky_i,
  input  logic [2:0]     rnd_i,
  output logic [SIG-1:0] frac_o,
  output logic           exp_inc_o,
  output logic           inexact_o
);

  logic           w_lsb;
  logic           w_guard;
  logic           w_rbit;
  logic           w_tail;
  logic           w_inc;
  logic [SIG+1:0] w_sum;

  assign w_lsb   = root_i[2];
  assign w_guard = root_i[1];
  assign w_rbit  = root_i[0];
  assign w_tail  = w_guard | w_rbit | sticky_i;

  // The root is never negative, so -inf behaves like truncation.
  always_comb begin
    w_inc = 1'b0;
    case (rnd_i)
      RND_ZERO, RND_NINF: w_inc = 1'b0;
      RND_PINF:           w_inc = w_tail;
      RND_UP:             w_inc = w_guard;
      default:            w_inc = w_guard & (w_rbit | sticky_i | w_lsb);
    endcase
  end

  assign w_sum     = {1'b0, root_i[SIG+2:2]} + (SIG+2)'(w_inc);
  assign exp_inc_o = w_sum[SIG+1];
  assign frac_o    = w_sum[SIG+1] ? w_sum[SIG:1] : w_sum[SIG-1:0];
  assign inexact_o = w_tail;

endmodule
`default_nettype wire

// File: rtl/fp_sqrt_seq.sv
`default_nettype none
// ============================================================================
// fp_sqrt_seq : fixed-latency IEEE-754 square root on XOR-shared operands,
//               radix-2 restoring recurrence. Status flags: FP_SQRT_STATUS_EN.
// Revision : 1.0
// ============================================================================
module fp_sqrt_seq
  import fp_pkg::*;
#(
  parameter int inst_sig_width       = 23,
  parameter int inst_exp_width       = 8,
  parameter int inst_ieee_compliance = 0
) (
  input logic          clk,
  input logic          rst,
  fp_sqrt_seq_if.slave sqrt_if
);

  localparam int SIG  = inst_sig_width;
  localparam int EXP  = inst_exp_width;
  localparam int W    = SIG + EXP + 1;
  localparam int N    = SIG + 3;
  localparam int RADW = 2 * N;
  localparam int REMW = SIG + 5;
  localparam int CNTW = $clog2(N);
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(SIG-1){1'b0}}};
  localparam logic [W-1:0] PINF = {1'b0, {EXP{1'b1}}, {SIG{1'b0}}};

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [2:0]      rnd_q, rnd_d;
  logic [RADW-1:0] rad_q, rad_d;
  logic [REMW-1:0] rem_q, rem_d;
  logic [N-1:0]    root_q, root_d;
  logic [EXP-1:0]  exp_q, exp_d;
  cls_e            cls_q, cls_d;
  logic [W-1:0]    o_q, o_d;

  logic [W+2:0]    w_shared;
  logic            w_sign;
  logic [EXP-1:0]  w_exp_fld;
  logic [SIG-1:0]  w_man;
  logic            w_odd;
  logic [SIG+1:0]  w_rad_init;
  logic [REMW+1:0] w_rem_t;
  logic [REMW+1:0] w_trial;
  logic [SIG-1:0]  w_frac;
  logic            w_exp_inc;
  logic            w_inexact;
  logic [W-1:0]    w_result;
  logic [7:0]      w_status;

  assign w_shared  = sqrt_if.g_input ^ sqrt_if.e_input;
  assign w_sign    = a_q[W-1];
  assign w_exp_fld = a_q[W-2:SIG];
  assign w_man     = a_q[SIG-1:0];
  // Bias is odd, so the unbiased exponent is odd exactly when the field is even.
  assign w_odd      = ~w_exp_fld[0];
  assign w_rad_init = w_odd ? {1'b1, w_man, 1'b0} : {2'b01, w_man};
  assign w_rem_t    = {rem_q, rad_q[RADW-1 -: 2]};
  assign w_trial    = {2'b00, root_q, 2'b01};

  fp_sqrt_round #(.SIG(SIG)) u_round (
    .root_i    (root_q),
    .sticky_i  (|rem_q),
    .rnd_i     (rnd_q),
    .frac_o    (w_frac),
    .exp_inc_o (w_exp_inc),
    .inexact_o (w_inexact)
  );

  always_comb begin
    w_result = {1'b0, exp_q + EXP'(w_exp_inc), w_frac};
    w_status = '0;
    case (cls_q)
      CLS_ZERO: begin
        w_result = {w_sign, {(W-1){1'b0}}};
        w_status[STAT_ZERO] = 1'b1;
      end
      CLS_INF: begin
        w_result = PINF;
        w_status[STAT_INF] = 1'b1;
      end
      CLS_NAN: begin
        w_result = QNAN;
        w_status[STAT_INVALID] = 1'b1;
      end
      default: w_status[STAT_INEXACT] = w_inexact;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rnd_d   = rnd_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    exp_d   = exp_q;
    cls_d   = cls_q;
    o_d     = o_q;
    case (state_q)
      ST_IDLE: begin
        if (sqrt_if.start) begin
          a_d     = w_shared[W-1:0];
          rnd_d   = w_shared[W+2:W];
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        if (w_exp_fld == '0)      cls_d = CLS_ZERO;
        else if (w_sign)          cls_d = CLS_NAN;
        else if (w_exp_fld == '1) cls_d = (w_man != '0) ? CLS_NAN : CLS_INF;
        else                      cls_d = CLS_NORM;
        rad_d   = {w_rad_init, {(RADW-SIG-2){1'b0}}};
        exp_d   = EXP'(({1'b0, w_exp_fld} + (EXP+1)'(BIAS)) >> 1);
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (w_rem_t >= w_trial) begin
          rem_d  = REMW'(w_rem_t - w_trial);
          root_d = {root_q[N-2:0], 1'b1};
        end else begin
          rem_d  = REMW'(w_rem_t);
          root_d = {root_q[N-2:0], 1'b0};
        end
        rad_d = rad_q << 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(N - 1)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        o_d     = w_result;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      rnd_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      exp_q   <= '0;
      cls_q   <= CLS_NORM;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rnd_q   <= rnd_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      exp_q   <= exp_d;
      cls_q   <= cls_d;
      o_q     <= o_d;
    end
  end

  assign sqrt_if.busy = (state_q == ST_UNPACK) || (state_q == ST_ITER) || (state_q == ST_ROUND);
  assign sqrt_if.done = (state_q == ST_DONE);
  assign sqrt_if.o    = o_q;

`ifdef FP_SQRT_STATUS_EN
  logic [7:0] status_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      status_q <= '0;
    else if (state_q == ST_ROUND) status_q <= w_status;
  end

  assign sqrt_if.status = status_q;
`else
  logic unused_status;
  assign unused_status  = ^w_status;
  assign sqrt_if.status = '0;
`endif

  logic unused_cfg;
  assign unused_cfg = (inst_ieee_compliance != 0);

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_seq.sv
`default_nettype none
// ============================================================================
// tb_fp_sqrt_seq : vector table, corner sequences and randomized model check
// Revision : 1.0
// ============================================================================
module tb_fp_sqrt_seq;
  import fp_pkg::*;

  localparam int LAT    = 28;
  localparam int BUDGET = 60;
  localparam int NVEC   = 16;
  localparam int NRAND  = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sqrt_seq_if #(.W(32)) bus ();

  fp_sqrt_seq dut (
    .clk     (clk),
    .rst     (rst),
    .sqrt_if (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [34:0] g;
    logic [34:0] e;
    logic [31:0] o;
    logic [7:0]  st;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] smask(input logic [7:0] s);
`ifdef FP_SQRT_STATUS_EN
    return s;
`else
    return 8'h00 & s;
`endif
  endfunction

  function automatic longint unsigned isqrt(input longint unsigned s);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 25;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= s) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  // Correctly rounded sqrt from an exact integer root and a midpoint comparison.
  function automatic void model(input logic [31:0] a, input logic [2:0] rnd,
                                output logic [31:0] o, output logic [7:0] st);
    int              ex;
    longint unsigned x, s, m, mid2;
    logic            inexact, above, tie, inc;
    st = 8'h00;
    o  = 32'h0;
    if (a[30:23] == 8'd0) begin
      o = {a[31], 31'd0};
      st[STAT_ZERO] = 1'b1;
    end else if (a[31] || (a[30:23] == 8'hFF && a[22:0] != 23'd0)) begin
      o = FP_QNAN;
      st[STAT_INVALID] = 1'b1;
    end else if (a[30:23] == 8'hFF) begin
      o = 32'h7F800000;
      st[STAT_INF] = 1'b1;
    end else begin
      ex = int'(a[30:23]) - 127;
      x  = {40'd0, 1'b1, a[22:0]};
      if ((ex & 1) != 0) begin
        x  = x << 1;
        ex = ex - 1;
      end
      s       = x << 23;
      m       = isqrt(s);
      inexact = (m * m != s);
      mid2    = (2 * m + 1) * (2 * m + 1);
      above   = (4 * s > mid2);
      tie     = (4 * s == mid2);
      case (rnd)
        3'd1, 3'd3: inc = 1'b0;
        3'd2:       inc = inexact;
        3'd4:       inc = above | tie;
        default:    inc = above | (tie & m[0]);
      endcase
      m  = m + 64'(inc);
      ex = ex / 2 + 127;
      if (m == (64'd1 << 24)) begin
        m  = 64'd1 << 23;
        ex = ex + 1;
      end
      o = {1'b0, ex[7:0], m[22:0]};
      st[STAT_INEXACT] = inexact;
    end
  endfunction

  task automatic run_op(input logic [34:0] g, input logic [34:0] e, input int repulse_at,
                        output logic [31:0] o, output logic [7:0] st);
    int cyc;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.g_input = g;
    bus.e_input = e;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.g_input = {3'($urandom), 32'($urandom)};
    bus.e_input = {3'($urandom), 32'($urandom)};
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      bus.start = (cyc + 1 == repulse_at);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LAT));
    o  = bus.o;
    st = bus.status;
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got_o, exp_o;
    logic [7:0]  got_st, exp_st;
    logic [34:0] mask;
    logic [31:0] a;
    logic [2:0]  rnd;
    logic [34:0] g;
    int          sel;
    logic        seen;

    tbl[0]  = '{{3'd0, 32'h40800000}, 35'd0, 32'h40000000, 8'h00};
    tbl[1]  = '{{3'd0, 32'h40000000}, 35'd0, 32'h3FB504F3, 8'h20};
    tbl[2]  = '{{3'd2, 32'h40000000}, 35'd0, 32'h3FB504F4, 8'h20};
    tbl[3]  = '{{3'd0, 32'h3F800000}, 35'd0, 32'h3F800000, 8'h00};
    tbl[4]  = '{{3'd0, 32'hBF800000}, 35'd0, 32'h7FC00000, 8'h04};
    tbl[5]  = '{{3'd0, 32'h80000000}, 35'd0, 32'h80000000, 8'h01};
    tbl[6]  = '{{3'd0, 32'h00000001}, 35'd0, 32'h00000000, 8'h01};
    tbl[7]  = '{{3'd0, 32'h7F800000}, 35'd0, 32'h7F800000, 8'h02};
    tbl[8]  = '{{3'd0, 32'h7FC00001}, 35'd0, 32'h7FC00000, 8'h04};
    tbl[9]  = '{{3'd0, 32'h407FFFFF}, 35'd0, 32'h3FFFFFFF, 8'h20};
    tbl[10] = '{{3'd2, 32'h407FFFFF}, 35'd0, 32'h40000000, 8'h20};
    tbl[11] = '{{3'd1, 32'h00800000}, 35'd0, 32'h20000000, 8'h00};
    tbl[12] = '{{3'd7, 32'h40000000}, 35'd0, 32'h3FB504F3, 8'h20};
    tbl[13] = '{{3'd0, 32'h52B456F8}, {3'd0, 32'h123456F8}, 32'h40000000, 8'h00};
    tbl[14] = '{{3'd3, 32'h40000000}, 35'd0, 32'h3FB504F3, 8'h20};
    tbl[15] = '{{3'd4, 32'h407FFFFF}, 35'd0, 32'h3FFFFFFF, 8'h20};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.g_input = '0;
    bus.e_input = '0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_o", bus.o, 32'd0);
    check("reset_status", 32'(bus.status), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      mask = {3'($urandom), 32'($urandom)};
      run_op(tbl[i].g ^ mask, tbl[i].e ^ mask, -1, got_o, got_st);
      check($sformatf("vec%0d_o", i), got_o, tbl[i].o);
      check($sformatf("vec%0d_status", i), 32'(got_st), 32'(smask(tbl[i].st)));
    end

    // Literal share pair: operand is the XOR of the two shares.
    model(32'h52B456F8 ^ 32'h12345678, 3'd0, exp_o, exp_st);
    run_op({3'd0, 32'h52B456F8}, {3'd0, 32'h12345678}, -1, got_o, got_st);
    check("share_pair_o", got_o, exp_o);
    check("share_pair_status", 32'(got_st), 32'(smask(exp_st)));

    for (int i = 0; i < NRAND; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel <= 1)      a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      else if (sel == 2) a = $urandom;
      else               a = {1'b0, 8'($urandom_range(1, 254)), 23'h7FFFFF ^ 23'($urandom_range(0, 3))};
      rnd = 3'($urandom_range(0, 7));
      g   = {3'($urandom), 32'($urandom)};
      model(a, rnd, exp_o, exp_st);
      run_op(g, g ^ {rnd, a}, -1, got_o, got_st);
      check($sformatf("rand%0d_o a=%h rnd=%0d", i, a, rnd), got_o, exp_o);
      check($sformatf("rand%0d_status", i), 32'(got_st), 32'(smask(exp_st)));
    end

    // Second start at cycle 5 carries scrambled shares and must be ignored.
    run_op({3'd0, 32'h40800000}, 35'd0, 5, got_o, got_st);
    check("repulse_o", got_o, 32'h40000000);
    check("repulse_status", 32'(got_st), 32'd0);

    // Abort at cycle 10.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.g_input = {3'd0, 32'h40000000};
    bus.e_input = 35'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_o", bus.o, 32'd0);
    check("abort_status", 32'(bus.status), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_op({3'd0, 32'h3F800000}, 35'd0, -1, got_o, got_st);
    check("post_abort_o", got_o, 32'h3F800000);
    check("post_abort_status", 32'(got_st), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
